// File: rtl/pvt_sched_pkg.sv
// Shared types for the PVT scan scheduler: FSM states, sensor-type decoding, sensor count.
// Pure definitions; no latency and no flow control of its own.
package pvt_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ENABLE,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      SEN_P = 2'd0,
      SEN_V = 2'd1,
      SEN_T = 2'd2
   } sen_type_e;

   typedef struct packed {
      sen_type_e  typ;
      logic [7:0] num;
   } sen_id_t;

   function automatic int num_sensors(input int p, input int v, input int t);
      return p + v + t;
   endfunction

   // Flat result index -> sensor family and number within that family.
   function automatic sen_id_t decode_idx(input int idx, input int p, input int v);
      sen_id_t r;
      if (idx < p) begin
         r.typ = SEN_P;
         r.num = 8'(idx);
      end else if (idx < p + v) begin
         r.typ = SEN_V;
         r.num = 8'(idx - p);
      end else begin
         r.typ = SEN_T;
         r.num = 8'(idx - p - v);
      end
      return r;
   endfunction

endpackage

// File: rtl/pvt_next_sel.sv
// Find-first-set over the latched sensor mask at or above the current index.
// Purely combinational, zero latency; no flow control.
module pvt_next_sel
   import pvt_sched_pkg::*;
#(
   parameter int N  = 22,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] cur,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Descending scan so the lowest qualifying bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(cur))) begin
            found = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/pvt_scan_scheduler.sv
// Walks enabled PVT sensors in index order: enable pulse, wait for valid or timeout, one result record each.
// Slot = 2 + EN_CYCLES + wait cycles, outputs registered; res_we has no backpressure, scan_abort/rst stop at once.
module pvt_scan_scheduler
   import pvt_sched_pkg::*;
#(
   parameter int  NO_OF_PSENSORS = 10,
   parameter int  NO_OF_VSENSORS = 4,
   parameter int  NO_OF_TSENSORS = 8,
   parameter int  EN_CYCLES      = 4,
   parameter int  TIMEOUT        = 255,
   parameter int  DATA_W         = 16,
   localparam int N              = num_sensors(NO_OF_PSENSORS, NO_OF_VSENSORS, NO_OF_TSENSORS),
   localparam int IW             = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scan_start,
   input  logic                scan_abort,
   input  logic                continuous,
   input  logic [N-1:0]        sensor_mask,
   output logic                busy,
   output logic                scan_done,
   output logic [N-1:0]        sen_en,
   input  logic [N-1:0]        sen_valid,
   input  logic [N*DATA_W-1:0] sen_data,
   output logic                res_we,
   output logic [IW-1:0]       res_idx,
   output logic [DATA_W-1:0]   res_data,
   output logic                res_timeout
);

   localparam int CMAX = (TIMEOUT > EN_CYCLES) ? TIMEOUT : EN_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   state_e              state_q, state_d;
   logic [IW-1:0]       cur_q, cur_d;
   logic [N-1:0]        mask_q, mask_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                scan_done_q, scan_done_d;
   logic [N-1:0]        sen_en_q, sen_en_d;
   logic                res_we_q, res_we_d;
   logic [IW-1:0]       res_idx_q, res_idx_d;
   logic [DATA_W-1:0]   res_data_q, res_data_d;
   logic                res_timeout_q, res_timeout_d;

   logic                nxt_found;
   logic [IW-1:0]       nxt_idx;

   pvt_next_sel #(
      .N  (N),
      .IW (IW)
   ) u_next_sel (
      .mask  (mask_q),
      .cur   (cur_q),
      .found (nxt_found),
      .idx   (nxt_idx)
   );

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      mask_d        = mask_q;
      cnt_d         = cnt_q;
      res_idx_d     = res_idx_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;

      if (scan_abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (scan_start && !scan_abort) begin
                  mask_d  = sensor_mask;
                  cur_d   = '0;
                  state_d = ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (nxt_found) begin
                  cur_d   = nxt_idx;
                  cnt_d   = CW'(1);
                  state_d = ST_ENABLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            ST_ENABLE: begin
               if (cnt_q == CW'(EN_CYCLES)) begin
                  cnt_d   = CW'(1);
                  state_d = ST_WAIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               // Valid is checked first so a valid on the final timeout cycle still captures data.
               if (sen_valid[cur_q]) begin
                  res_idx_d     = cur_q;
                  res_data_d    = sen_data[int'(cur_q)*DATA_W +: DATA_W];
                  res_timeout_d = 1'b0;
                  state_d       = ST_WRITE;
               end else if (cnt_q == CW'(TIMEOUT)) begin
                  res_idx_d     = cur_q;
                  res_data_d    = '0;
                  res_timeout_d = 1'b1;
                  state_d       = ST_WRITE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WRITE: begin
               if (cur_q == IW'(N - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = ST_SELECT;
               end
            end
            ST_DONE: begin
               if (continuous) begin
                  mask_d  = sensor_mask;
                  cur_d   = '0;
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they line up with the state they describe.
      busy_d      = (state_d != ST_IDLE);
      scan_done_d = (state_d == ST_DONE);
      res_we_d    = (state_d == ST_WRITE);
      sen_en_d    = '0;
      if (state_d == ST_ENABLE) begin
         sen_en_d[cur_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cur_q         <= '0;
         mask_q        <= '0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         scan_done_q   <= 1'b0;
         sen_en_q      <= '0;
         res_we_q      <= 1'b0;
         res_idx_q     <= '0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         mask_q        <= mask_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         scan_done_q   <= scan_done_d;
         sen_en_q      <= sen_en_d;
         res_we_q      <= res_we_d;
         res_idx_q     <= res_idx_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   assign busy        = busy_q;
   assign scan_done   = scan_done_q;
   assign sen_en      = sen_en_q;
   assign res_we      = res_we_q;
   assign res_idx     = res_idx_q;
   assign res_data    = res_data_q;
   assign res_timeout = res_timeout_q;

endmodule
